// File: rtl/fpu_decode_stage.sv
// fpu_decode_stage: Zhinx half-precision FPU instruction decode stage.
// Optional FPU_DECODE_SKID_EN: 2-entry skid buffer, registered in_ready.
module fpu_decode_stage (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_insn,
    input  logic [15:0] in_rs1_val,
    input  logic [15:0] in_rs2_val,
    input  logic [15:0] in_rs3_val,
    input  logic        frm_we,
    input  logic [2:0]  frm_wdata,
    output logic [2:0]  frm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [2:0]  out_rm,
    output logic [2:0]  out_sub,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [15:0] out_c,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_OPFP  = 7'b1010011;
    localparam logic [6:0] OPC_MADD  = 7'b1000011;
    localparam logic [6:0] OPC_MSUB  = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB = 7'b1001011;
    localparam logic [6:0] OPC_NMADD = 7'b1001111;
    localparam logic [1:0] FMT_HALF  = 2'b10;
    localparam logic [2:0] RM_DYN    = 3'b111;

    localparam logic [4:0] F5_ADD    = 5'b00000;
    localparam logic [4:0] F5_SUB    = 5'b00001;
    localparam logic [4:0] F5_MUL    = 5'b00010;
    localparam logic [4:0] F5_DIV    = 5'b00011;
    localparam logic [4:0] F5_SGNJ   = 5'b00100;
    localparam logic [4:0] F5_MINMAX = 5'b00101;
    localparam logic [4:0] F5_SQRT   = 5'b01011;
    localparam logic [4:0] F5_COMP   = 5'b10100;
    localparam logic [4:0] F5_CLASS  = 5'b11100;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_MIN   = 4'd4;
    localparam logic [3:0] OP_MAX   = 4'd5;
    localparam logic [3:0] OP_SQRT  = 4'd6;
    localparam logic [3:0] OP_SGNJ  = 4'd7;
    localparam logic [3:0] OP_COMP  = 4'd8;
    localparam logic [3:0] OP_CLASS = 4'd9;
    localparam logic [3:0] OP_MADD  = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_NMADD = 4'd12;
    localparam logic [3:0] OP_NMSUB = 4'd13;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  rm;
        logic [2:0]  sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [4:0]  rd;
        logic        ill;
    } dec_t;

    logic [6:0] opc;
    logic [4:0] f5;
    logic [1:0] fmt;
    logic [4:0] rs2;
    logic [2:0] rm;
    logic [4:0] rd;
    logic       unused_rs1;

    assign opc        = in_insn[6:0];
    assign rd         = in_insn[11:7];
    assign rm         = in_insn[14:12];
    assign rs2        = in_insn[24:20];
    assign fmt        = in_insn[26:25];
    assign f5         = in_insn[31:27];
    assign unused_rs1 = ^in_insn[19:15];

    logic [2:0] frm_q;
    logic [3:0] op;
    logic       known;
    logic       use_rm;
    logic       is_r4;
    logic       rm_bad;
    logic       legal;
    dec_t       dec;

    assign frm = frm_q;

    // Dynamic rounding-mode CSR; decode in the same cycle sees the old value.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) frm_q <= 3'b000;
        else if (frm_we) frm_q <= frm_wdata;
    end

    // Opcode / funct5 / subselect classification.
    always_comb begin
        op     = OP_ADD;
        known  = 1'b0;
        use_rm = 1'b0;
        is_r4  = 1'b0;
        if (fmt == FMT_HALF) begin
            case (opc)
                OPC_OPFP: begin
                    case (f5)
                        F5_ADD: begin
                            op = OP_ADD; known = 1'b1; use_rm = 1'b1;
                        end
                        F5_SUB: begin
                            op = OP_SUB; known = 1'b1; use_rm = 1'b1;
                        end
                        F5_MUL: begin
                            op = OP_MUL; known = 1'b1; use_rm = 1'b1;
                        end
                        F5_DIV: begin
                            op = OP_DIV; known = 1'b1; use_rm = 1'b1;
                        end
                        F5_SQRT: begin
                            op = OP_SQRT; use_rm = 1'b1;
                            known = (rs2 == 5'd0);
                        end
                        F5_MINMAX: begin
                            op = rm[0] ? OP_MAX : OP_MIN;
                            known = (rm[2:1] == 2'b00);
                        end
                        F5_SGNJ: begin
                            op = OP_SGNJ;
                            known = (rm <= 3'b010);
                        end
                        F5_COMP: begin
                            op = OP_COMP;
                            known = (rm <= 3'b010);
                        end
                        F5_CLASS: begin
                            op = OP_CLASS;
                            known = (rm == 3'b001) && (rs2 == 5'd0);
                        end
                        default: known = 1'b0;
                    endcase
                end
                OPC_MADD: begin
                    op = OP_MADD; known = 1'b1;
                    use_rm = 1'b1; is_r4 = 1'b1;
                end
                OPC_MSUB: begin
                    op = OP_MSUB; known = 1'b1;
                    use_rm = 1'b1; is_r4 = 1'b1;
                end
                OPC_NMADD: begin
                    op = OP_NMADD; known = 1'b1;
                    use_rm = 1'b1; is_r4 = 1'b1;
                end
                OPC_NMSUB: begin
                    op = OP_NMSUB; known = 1'b1;
                    use_rm = 1'b1; is_r4 = 1'b1;
                end
                default: known = 1'b0;
            endcase
        end
    end

    // Rounding-mode legality and resolution, then the output bundle.
    always_comb begin
        rm_bad = (rm == 3'b101) || (rm == 3'b110) ||
                 ((rm == RM_DYN) && (frm_q >= 3'b101));
        legal  = known && !(use_rm && rm_bad);
        dec    = '0;
        dec.rd = rd;
        if (legal) begin
            dec.op  = op;
            dec.rm  = use_rm ? ((rm == RM_DYN) ? frm_q : rm) : 3'b000;
            dec.sub = rm;
            dec.a   = in_rs1_val;
            dec.b   = in_rs2_val;
            dec.c   = is_r4 ? in_rs3_val : 16'h0000;
        end else begin
            dec.ill = 1'b1;
        end
    end

    dec_t ent0;

`ifdef FPU_DECODE_SKID_EN
    dec_t       ent1;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;
    logic       rdy_q;
    logic       push;
    logic       pop;

    assign in_ready  = rdy_q;
    assign out_valid = (cnt != 2'd0);
    assign push      = in_valid && rdy_q;
    assign pop       = out_valid && out_ready;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop) cnt_nxt = cnt + 2'd1;
        else if (pop && !push) cnt_nxt = cnt - 2'd1;
    end

    // Two-entry FIFO; ent0 is the head driving the outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt   <= 2'd0;
            rdy_q <= 1'b1;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            cnt   <= cnt_nxt;
            rdy_q <= (cnt_nxt != 2'd2);
            if (pop && cnt == 2'd2) ent0 <= ent1;
            else if (push && cnt_nxt == 2'd1) ent0 <= dec;
            if (push && cnt_nxt == 2'd2) ent1 <= dec;
        end
    end
`else
    logic vld_q;

    assign in_ready  = !vld_q || out_ready;
    assign out_valid = vld_q;

    // Single output register, reloaded whenever it is empty or draining.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vld_q <= 1'b0;
            ent0  <= '0;
        end else if (in_ready) begin
            vld_q <= in_valid;
            if (in_valid) ent0 <= dec;
        end
    end
`endif

    assign out_op      = ent0.op;
    assign out_rm      = ent0.rm;
    assign out_sub     = ent0.sub;
    assign out_a       = ent0.a;
    assign out_b       = ent0.b;
    assign out_c       = ent0.c;
    assign out_rd      = ent0.rd;
    assign out_illegal = ent0.ill;

endmodule

// File: tb/tb_fpu_decode_stage.sv
// tb_fpu_decode_stage: directed checks for the Zhinx FPU decode stage.
// Drive and sample at 1 time unit after the rising edge.
module tb_fpu_decode_stage;

    logic        CLK;
    logic        nRST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_insn;
    logic [15:0] in_rs1_val;
    logic [15:0] in_rs2_val;
    logic [15:0] in_rs3_val;
    logic        frm_we;
    logic [2:0]  frm_wdata;
    logic [2:0]  frm;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [2:0]  out_rm;
    logic [2:0]  out_sub;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] out_c;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FPU_DECODE_SKID_EN
    localparam int EXP_ACC = 2;
`else
    localparam int EXP_ACC = 1;
`endif

    localparam logic [6:0] MADD  = 7'b1000011;
    localparam logic [6:0] NMSUB = 7'b1001011;
    localparam logic [6:0] NMADD = 7'b1001111;

    fpu_decode_stage dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_insn(in_insn),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_rs3_val(in_rs3_val),
        .frm_we(frm_we), .frm_wdata(frm_wdata), .frm(frm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rm(out_rm), .out_sub(out_sub),
        .out_a(out_a), .out_b(out_b), .out_c(out_c),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] opfp(
        input logic [4:0] f5, input logic [1:0] fmt,
        input logic [4:0] rs2, input logic [2:0] rm,
        input logic [4:0] rd);
        return {f5, fmt, rs2, 5'd1, rm, rd, 7'b1010011};
    endfunction

    function automatic logic [31:0] r4(
        input logic [6:0] opc, input logic [2:0] rm,
        input logic [4:0] rd);
        return {5'd3, 2'b10, 5'd2, 5'd1, rm, rd, opc};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] insn, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] c);
        in_valid = 1'b1;
        in_insn = insn;
        in_rs1_val = a;
        in_rs2_val = b;
        in_rs3_val = c;
        step();
        in_valid = 1'b0;
    endtask

    task automatic set_frm(input logic [2:0] v);
        frm_we = 1'b1;
        frm_wdata = v;
        step();
        frm_we = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL rst_valid: got %b required 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        n_checks++; if (frm !== 3'd0) begin n_fail++;
            $display("FAIL rst_frm: got %0d required 0", frm); end
        n_checks++; if ({out_op, out_rm, out_sub, out_a, out_b, out_c,
                         out_rd, out_illegal} !== '0) begin n_fail++;
            $display("FAIL rst_outs: got op=%0d a=%h rd=%0d ill=%b required 0",
                     out_op, out_a, out_rd, out_illegal); end
        step();
        nRST = 1'b1;
    endtask

    task automatic test_fadd();
        set_frm(3'b011);
        n_checks++; if (frm !== 3'b011) begin n_fail++;
            $display("FAIL frm_write: got %0d required 3", frm); end
        drive(opfp(5'b00000, 2'b10, 5'd2, 3'b111, 5'd5),
              16'h3C00, 16'h4000, 16'h7777);
        n_checks++; if (out_valid !== 1'b1 || out_op !== 4'd0 ||
                        out_illegal !== 1'b0) begin n_fail++;
            $display("FAIL fadd_op: got v=%b op=%0d ill=%b required 1 0 0",
                     out_valid, out_op, out_illegal); end
        n_checks++; if (out_rm !== 3'b011 || out_sub !== 3'b111) begin
            n_fail++;
            $display("FAIL fadd_rm: got rm=%0d sub=%0d required 3 7",
                     out_rm, out_sub); end
        n_checks++; if (out_a !== 16'h3C00 || out_b !== 16'h4000 ||
                        out_c !== 16'h0 || out_rd !== 5'd5) begin n_fail++;
            $display("FAIL fadd_ops: got %h %h %h rd=%0d required 3c00 4000 0 5",
                     out_a, out_b, out_c, out_rd); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL fadd_drain: got %b required 0", out_valid); end
    endtask

    task automatic test_r4();
        drive(r4(MADD, 3'b010, 5'd6), 16'h1111, 16'h2222, 16'h3333);
        n_checks++; if (out_op !== 4'd10 || out_rm !== 3'd2 ||
                        out_c !== 16'h3333 || out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL fmadd: got op=%0d rm=%0d c=%h required 10 2 3333",
                     out_op, out_rm, out_c); end
        drive(r4(NMSUB, 3'b000, 5'd7), 16'h1, 16'h2, 16'h4444);
        n_checks++; if (out_op !== 4'd13 || out_rm !== 3'd0 ||
                        out_c !== 16'h4444) begin n_fail++;
            $display("FAIL fnmsub: got op=%0d rm=%0d c=%h required 13 0 4444",
                     out_op, out_rm, out_c); end
        drive(r4(NMADD, 3'b111, 5'd8), 16'h1, 16'h2, 16'h5555);
        n_checks++; if (out_op !== 4'd12 || out_rm !== 3'd3) begin n_fail++;
            $display("FAIL fnmadd: got op=%0d rm=%0d required 12 3",
                     out_op, out_rm); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        in_insn = opfp(5'b00101, 2'b10, 5'd2, 3'b001, 5'd11);
        step();
        n_checks++; if (out_valid !== 1'b1 || out_op !== 4'd5 ||
                        out_sub !== 3'd1 || out_rm !== 3'd0) begin n_fail++;
            $display("FAIL b2b_max: got v=%b op=%0d sub=%0d rm=%0d required 1 5 1 0",
                     out_valid, out_op, out_sub, out_rm); end
        in_insn = opfp(5'b00101, 2'b10, 5'd2, 3'b000, 5'd12);
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_op !== 4'd4 ||
                        out_rd !== 5'd12) begin n_fail++;
            $display("FAIL b2b_min: got v=%b op=%0d rd=%0d required 1 4 12",
                     out_valid, out_op, out_rd); end
    endtask

    task automatic test_illegal();
        drive(opfp(5'b01011, 2'b10, 5'd1, 3'b000, 5'd9),
              16'hAAAA, 16'hBBBB, 16'hCCCC);
        n_checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 ||
                        out_op !== 4'd0 || out_rd !== 5'd9) begin n_fail++;
            $display("FAIL sqrt_rs2: got v=%b ill=%b op=%0d rd=%0d required 1 1 0 9",
                     out_valid, out_illegal, out_op, out_rd); end
        n_checks++; if (out_a !== 16'h0 || out_b !== 16'h0 ||
                        out_c !== 16'h0) begin n_fail++;
            $display("FAIL sqrt_ops: got %h %h %h required 0 0 0",
                     out_a, out_b, out_c); end
        drive(opfp(5'b00000, 2'b00, 5'd2, 3'b000, 5'd9), 16'h1, 16'h2, 16'h3);
        n_checks++; if (out_illegal !== 1'b1) begin n_fail++;
            $display("FAIL bad_fmt: got %b required 1", out_illegal); end
        drive(opfp(5'b00000, 2'b10, 5'd2, 3'b101, 5'd9), 16'h1, 16'h2, 16'h3);
        n_checks++; if (out_illegal !== 1'b1) begin n_fail++;
            $display("FAIL rm_101: got %b required 1", out_illegal); end
        drive(opfp(5'b00100, 2'b10, 5'd2, 3'b011, 5'd9), 16'h1, 16'h2, 16'h3);
        n_checks++; if (out_illegal !== 1'b1) begin n_fail++;
            $display("FAIL sgnj_sub: got %b required 1", out_illegal); end
        drive(opfp(5'b11100, 2'b10, 5'd0, 3'b001, 5'd14), 16'h1, 16'h2, 16'h3);
        n_checks++; if (out_illegal !== 1'b0 || out_op !== 4'd9 ||
                        out_rm !== 3'd0 || out_sub !== 3'd1) begin n_fail++;
            $display("FAIL fclass: got ill=%b op=%0d rm=%0d sub=%0d required 0 9 0 1",
                     out_illegal, out_op, out_rm, out_sub); end
        drive(opfp(5'b01011, 2'b10, 5'd0, 3'b001, 5'd15), 16'h1, 16'h2, 16'h3);
        n_checks++; if (out_illegal !== 1'b0 || out_op !== 4'd6 ||
                        out_rm !== 3'd1) begin n_fail++;
            $display("FAIL fsqrt: got ill=%b op=%0d rm=%0d required 0 6 1",
                     out_illegal, out_op, out_rm); end
        set_frm(3'b101);
        drive(opfp(5'b00000, 2'b10, 5'd2, 3'b111, 5'd9), 16'h1, 16'h2, 16'h3);
        n_checks++; if (out_illegal !== 1'b1 || out_rm !== 3'd0) begin
            n_fail++;
            $display("FAIL dyn_bad_frm: got ill=%b rm=%0d required 1 0",
                     out_illegal, out_rm); end
        set_frm(3'b000);
    endtask

    task automatic test_frm_same_cycle();
        frm_we = 1'b1;
        frm_wdata = 3'b001;
        drive(opfp(5'b00010, 2'b10, 5'd2, 3'b111, 5'd3), 16'h1, 16'h2, 16'h3);
        frm_we = 1'b0;
        n_checks++; if (out_op !== 4'd2 || out_rm !== 3'd0 ||
                        frm !== 3'd1) begin n_fail++;
            $display("FAIL frm_same: got op=%0d rm=%0d frm=%0d required 2 0 1",
                     out_op, out_rm, frm); end
        drive(opfp(5'b00010, 2'b10, 5'd2, 3'b111, 5'd3), 16'h1, 16'h2, 16'h3);
        n_checks++; if (out_rm !== 3'd1) begin n_fail++;
            $display("FAIL frm_next: got rm=%0d required 1", out_rm); end
    endtask

    task automatic test_backpressure();
        int idx;
        int got;
        logic acc;
        logic [15:0] snap_a;
        logic [4:0] got_rd [4];
        step();
        out_ready = 1'b0;
        idx = 0;
        snap_a = 16'h0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid = 1'b1;
            in_insn = opfp(5'b00000, 2'b10, 5'd2, 3'b000, 5'(10 + idx));
            in_rs1_val = 16'h0100 + 16'(idx);
            acc = in_ready;
            step();
            if (acc) idx++;
            if (cyc == 0) snap_a = out_a;
        end
        in_valid = 1'b0;
        n_checks++; if (idx != EXP_ACC) begin n_fail++;
            $display("FAIL fill_count: got %0d required %0d", idx, EXP_ACC); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL fill_ready: got %b required 0", in_ready); end
        n_checks++; if (out_valid !== 1'b1 || out_rd !== 5'd10 ||
                        out_a !== 16'h0100 || out_a !== snap_a) begin
            n_fail++;
            $display("FAIL fill_hold: got v=%b rd=%0d a=%h required 1 10 0100",
                     out_valid, out_rd, out_a); end
        out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid === 1'b1 && got < 4) begin
                got_rd[got] = out_rd;
                got++;
            end
            step();
        end
        n_checks++; if (got != EXP_ACC) begin n_fail++;
            $display("FAIL drain_count: got %0d required %0d", got, EXP_ACC); end
        for (int i = 0; i < got; i++) begin
            n_checks++; if (got_rd[i] !== 5'(10 + i)) begin n_fail++;
                $display("FAIL drain_order: got rd=%0d required %0d",
                         got_rd[i], 10 + i); end
        end
    endtask

    task automatic test_reset_midflight();
        set_frm(3'b110);
        out_ready = 1'b0;
        drive(opfp(5'b00001, 2'b10, 5'd2, 3'b000, 5'd20), 16'h9, 16'h8, 16'h7);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++;
            $display("FAIL pre_rst_valid: got %b required 1", out_valid); end
        #2;
        nRST = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || frm !== 3'd0 ||
                        in_ready !== 1'b1 || out_rd !== 5'd0) begin n_fail++;
            $display("FAIL async_rst: got v=%b frm=%0d rdy=%b rd=%0d required 0 0 1 0",
                     out_valid, frm, in_ready, out_rd); end
        out_ready = 1'b1;
        step();
        nRST = 1'b1;
        drive(opfp(5'b00001, 2'b10, 5'd2, 3'b000, 5'd4), 16'h9, 16'h8, 16'h7);
        n_checks++; if (out_valid !== 1'b1 || out_op !== 4'd1 ||
                        out_rd !== 5'd4) begin n_fail++;
            $display("FAIL post_rst: got v=%b op=%0d rd=%0d required 1 1 4",
                     out_valid, out_op, out_rd); end
    endtask

    initial begin
        CLK = 1'b0;
        nRST = 1'b0;
        in_valid = 1'b0;
        in_insn = '0;
        in_rs1_val = '0;
        in_rs2_val = '0;
        in_rs3_val = '0;
        frm_we = 1'b0;
        frm_wdata = '0;
        out_ready = 1'b1;
        test_reset();
        test_fadd();
        test_r4();
        test_back_to_back();
        test_illegal();
        test_frm_same_cycle();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_decode_stage.md
FPU_DECODE_STAGE -- requirements
Module: fpu_decode_stage

Interface
REQ-001 SHALL: CLK  in  1  single clock, rising-edge.
REQ-002 SHALL: nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: in_valid  in  1  upstream instruction valid.
REQ-004 SHALL: in_ready  out  1  stage accepts instruction this cycle.
REQ-005 SHALL: in_insn  in  32  rv32zhinx_insn_t; rs3 = in_insn[31:27] for R4 opcodes.
REQ-006 SHALL: in_rs1_val, in_rs2_val, in_rs3_val  in  16 each  Zhinx operand values from the integer register file, low half.
REQ-007 SHALL: frm_we  in  1, frm_wdata  in  3  dynamic rounding-mode CSR write.
REQ-008 SHALL: frm  out  3  current frm register.
REQ-009 SHALL: out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-010 SHALL: out_op  out  4  fpu_operation_t ordinal (FPU_HALF_ADD=0 .. FPU_HALF_NMSUB=13).
REQ-011 SHALL: out_rm  out  3  resolved rounding mode, never RM_DYN.
REQ-012 SHALL: out_sub  out  3  raw rm field for MIN/MAX, SGNJ and COMP subselect.
REQ-013 SHALL: out_a, out_b, out_c  out  16 each; out_rd  out  5; out_illegal  out  1.

Function
REQ-014 SHALL: accept on in_valid && in_ready; decoded result appears on outputs at the next rising edge (latency 1).
REQ-015 SHALL: hold all out_* stable while out_valid && !out_ready; transfer completes on out_valid && out_ready.
REQ-016 SHALL: decode OPCODE_OPFP only with fmt==FMT_HALF: FADD/FSUB/FMUL/FDIV -> ADD/SUB/MUL/DIV; FMINMAX rm 000 -> MIN, rm 001 -> MAX; FSQRT -> SQRT, requires rs2==0; FSGNJ rm 000/001/010 -> SGNJ; FCOMP rm 000/001/010 -> COMP; FCLASS rm 001, rs2==0 -> CLASS.
REQ-017 SHALL: decode FMADD/FMSUB/FNMADD/FNMSUB opcodes with insn[26:25]==FMT_HALF -> MADD/MSUB/NMADD/NMSUB; out_c = in_rs3_val, else out_c = 0.
REQ-018 SHALL: for ADD/SUB/MUL/DIV/SQRT/R4 ops, out_rm = frm when rm==RM_DYN, else rm; for other ops out_rm = 000.
REQ-019 SHALL: flag out_illegal=1 for unknown opcode/funct5, fmt!=FMT_HALF, bad subselect, nonzero rs2 where required, rm 101/110, or rm==RM_DYN with frm in 101..111.
REQ-020 SHALL: illegal instructions still produce out_valid=1 with out_illegal=1, out_op=0, out_a/b/c=0, out_rd passed through.
REQ-021 SHALL: out_sub = in_insn.rm for all legal ops.
REQ-022 SHALL: frm_we updates frm at the clock edge; an instruction accepted in that same cycle resolves with the old frm.

Reset
REQ-023 SHALL: on nRST low, immediately: out_valid=0, in_ready=1, frm=000, every other out_* = 0; buffered entries discarded.
REQ-024 SHALL: reset mid-transfer drops the in-flight instruction; first acceptance possible on the first edge after nRST rises.

Configuration
REQ-025 SHALL: with FPU_DECODE_SKID_EN defined, a 2-entry skid buffer is present; in_ready is a pure register output, deasserted only when both entries are full; throughput 1/cycle under continuous out_ready.
REQ-026 SHALL: without FPU_DECODE_SKID_EN, a single output register is used; in_ready = !out_valid || out_ready (combinational); throughput still 1/cycle.
REQ-027 SHALL: ordering, latency and decode results are identical in both configurations.

Verification
REQ-028 SHALL: fadd.h, rm=RM_DYN, frm=011, rs1=0x3C00, rs2=0x4000 -> next cycle out_op=0, out_rm=011, out_a=0x3C00, out_b=0x4000, out_illegal=0.
REQ-029 SHALL: fmax.h rm=001 then fmin.h rm=000 back-to-back, out_ready=1 -> out_op=5 then 4 on consecutive cycles.
REQ-030 SHALL: fsqrt.h with rs2=00001 -> out_valid=1, out_illegal=1, out_op=0, operands 0.
REQ-031 SHALL: frm_we=1, frm_wdata=001 same cycle as accepted fmul.h rm=111 with frm=000 -> out_rm=000; next fmul.h -> out_rm=001.
REQ-032 SHALL: fill with out_ready=0 for 4 cycles -> with skid macro 2 accepted, in_ready=0, outputs stable; without it 1 accepted; release -> in-order drain, no loss.
REQ-033 SHALL: assert nRST low while out_valid=1 -> out_valid=0 and frm=000 without a clock edge.
